// File: rtl/dispatch_pkg.sv
// Shared definitions for the dispatch queue: RV32I opcode constants, the issue
// class encoding, the queued instruction and ROB allocation records, and the
// helper that produces the "no dependency" tag for a given ROB index width.
package dispatch_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Where the head instruction goes; ClsNone means "drop silently".
    typedef enum logic [1:0] {
        ClsNone,
        ClsRs,
        ClsLsb,
        ClsRob
    } cls_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        pred;
    } inst_t;

    localparam int unsigned INST_W = $bits(inst_t);

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pred;
        logic        rdy;
        logic [31:0] data;
    } rob_t;

    function automatic cls_e classify(input logic [6:0] op);
        case (op)
            OP_OP, OP_IMM, OP_BRANCH, OP_JALR: return ClsRs;
            OP_LOAD, OP_STORE:                 return ClsLsb;
            OP_LUI, OP_AUIPC, OP_JAL:          return ClsRob;
            default:                           return ClsNone;
        endcase
    endfunction

    // Tag one past the largest ROB index: operand value is already available.
    function automatic logic [31:0] non_dep(input int unsigned rob_w);
        return 32'd1 << rob_w;
    endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Instruction-fetch to dispatch handshake.
//   in_valid / in_ready : transfer when both are high on a clock edge
//   in_pc, in_opcode, in_rs1, in_rs2, in_rd, in_imm, in_pred : decoded instruction
// master = fetch side, slave = dispatch queue.
interface dispatch_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        in_pred;

    modport master (
        output in_valid, in_pc, in_opcode, in_rs1, in_rs2, in_rd, in_imm, in_pred,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_opcode, in_rs1, in_rs2, in_rd, in_imm, in_pred,
        output in_ready
    );
endinterface

// File: rtl/dispatch_fifo.sv
// In-order storage for the dispatch queue.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   i_push, i_data : write one entry (caller guarantees not full)
//   i_pop          : retire the head (caller guarantees not empty)
//   i_flush        : discard all entries; wins over push/pop
//   o_head         : head entry, valid while o_count != 0
//   o_count        : occupancy, 0 .. 2**ADDR_W
module dispatch_fifo #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_head,
    output logic [ADDR_W:0]   o_count
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [ADDR_W:0]   r_count;

    // Pointers are exactly ADDR_W bits, so increment wraps modulo the depth.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
endmodule

// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instructions in order and issues the head to
// the reservation station (ALU ops), load/store buffer (memory ops) or ROB only
// (lui/auipc/jal), allocating a ROB entry and renaming rd in the register file.
//   clk_in, rst_in, rdy_in, flush_in : clock, async reset, run enable, flush
//   in_if (slave)        : fetch handshake and decoded instruction
//   rf_rs1/rf_rs2 -> rf_qj/rf_qk/rf_vj/rf_vk : combinational RF read for the head
//   cdb_*                : result broadcast
//   rob_full, rob_idx, rs_full, lsb_full : backend status
//   rs_*, lsb_*, rob_*, rf_en/rf_rob/rf_rd : registered issue outputs, *_en pulses
// Optional: define CDB_BYPASS_EN to forward a same-cycle CDB result into the
// issued operands instead of the stale RF tag.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int unsigned RoB_WIDTH   = 3,
    parameter int unsigned QUEUE_WIDTH = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    dispatch_queue_if.slave      in_if,
    output logic [4:0]           rf_rs1,
    output logic [4:0]           rf_rs2,
    input  logic [RoB_WIDTH:0]   rf_qj,
    input  logic [RoB_WIDTH:0]   rf_qk,
    input  logic [31:0]          rf_vj,
    input  logic [31:0]          rf_vk,
    input  logic                 cdb_valid,
    input  logic [RoB_WIDTH-1:0] cdb_rob,
    input  logic [31:0]          cdb_data,
    input  logic                 rob_full,
    input  logic [RoB_WIDTH-1:0] rob_idx,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    output logic                 rs_en,
    output logic [RoB_WIDTH-1:0] rs_rob,
    output logic [6:0]           rs_op,
    output logic [31:0]          rs_vj,
    output logic [31:0]          rs_vk,
    output logic [RoB_WIDTH:0]   rs_qj,
    output logic [RoB_WIDTH:0]   rs_qk,
    output logic [31:0]          rs_imm,
    output logic [31:0]          rs_pc,
    output logic                 lsb_en,
    output logic [RoB_WIDTH-1:0] lsb_rob,
    output logic [6:0]           lsb_op,
    output logic [31:0]          lsb_vj,
    output logic [31:0]          lsb_vk,
    output logic [RoB_WIDTH:0]   lsb_qj,
    output logic [RoB_WIDTH:0]   lsb_qk,
    output logic [31:0]          lsb_imm,
    output logic [31:0]          lsb_pc,
    output logic                 rob_en,
    output logic [6:0]           rob_op,
    output logic [4:0]           rob_rd,
    output logic [31:0]          rob_pc,
    output logic [31:0]          rob_npc,
    output logic                 rob_pred,
    output logic                 rob_rdy,
    output logic [31:0]          rob_data,
    output logic                 rf_en,
    output logic [RoB_WIDTH-1:0] rf_rob,
    output logic [4:0]           rf_rd
);
    localparam logic [31:0]        NON_DEP_W = non_dep(RoB_WIDTH);
    localparam logic [RoB_WIDTH:0] NON_DEP   = NON_DEP_W[RoB_WIDTH:0];

    typedef struct packed {
        logic [RoB_WIDTH-1:0] rob;
        logic [6:0]           op;
        logic [31:0]          vj;
        logic [31:0]          vk;
        logic [RoB_WIDTH:0]   qj;
        logic [RoB_WIDTH:0]   qk;
        logic [31:0]          imm;
        logic [31:0]          pc;
    } ops_t;

    inst_t                w_in_inst;
    inst_t                w_head;
    cls_e                 w_cls;
    logic [QUEUE_WIDTH:0] w_count;
    logic                 w_empty, w_full, w_push, w_pop, w_target_ok, w_rf_write;
    logic [RoB_WIDTH:0]   w_qj, w_qk;
    logic [31:0]          w_vj, w_vk;
    ops_t                 w_ops, r_ops;
    rob_t                 w_rob, r_rob;
    logic                 r_ready, r_rs_en, r_lsb_en, r_rob_en, r_rf_en;
    logic [RoB_WIDTH-1:0] r_rf_rob;
    logic [4:0]           r_rf_rd;

    assign w_in_inst = '{pc: in_if.in_pc, opcode: in_if.in_opcode, rs1: in_if.in_rs1,
                         rs2: in_if.in_rs2, rd: in_if.in_rd, imm: in_if.in_imm,
                         pred: in_if.in_pred};

    assign w_cls   = classify(w_head.opcode);
    assign w_empty = (w_count == '0);
    assign w_full  = w_count[QUEUE_WIDTH];
    // r_ready keeps in_ready low through reset and until the first edge after it.
    assign in_if.in_ready = r_ready && rdy_in && !w_full;
    assign w_push = in_if.in_valid && in_if.in_ready && !flush_in;
    assign w_pop  = rdy_in && !flush_in && !w_empty && w_target_ok;

    dispatch_fifo #(
        .WIDTH (INST_W),
        .ADDR_W(QUEUE_WIDTH)
    ) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_flush(flush_in),
        .i_data (w_in_inst),
        .o_head (w_head),
        .o_count(w_count)
    );

    // Unrecognised opcodes need no resources and are dropped as soon as they reach the head.
    always_comb begin
        w_target_ok = 1'b1;
        unique case (w_cls)
            ClsRs:   w_target_ok = !rob_full && !rs_full;
            ClsLsb:  w_target_ok = !rob_full && !lsb_full;
            ClsRob:  w_target_ok = !rob_full;
            ClsNone: w_target_ok = 1'b1;
        endcase
    end

    always_comb begin
        rf_rs1 = '0;
        rf_rs2 = '0;
        if (!w_empty) begin
            if (!(w_head.opcode inside {OP_LUI, OP_AUIPC, OP_JAL})) rf_rs1 = w_head.rs1;
            if (w_head.opcode inside {OP_OP, OP_BRANCH, OP_STORE})  rf_rs2 = w_head.rs2;
        end
    end

`ifdef CDB_BYPASS_EN
    // A result broadcast this cycle has not reached the RF yet; take it from the CDB.
    always_comb begin
        w_qj = rf_qj;
        w_vj = rf_vj;
        w_qk = rf_qk;
        w_vk = rf_vk;
        if (cdb_valid && (rf_qj == {1'b0, cdb_rob})) begin
            w_qj = NON_DEP;
            w_vj = cdb_data;
        end
        if (cdb_valid && (rf_qk == {1'b0, cdb_rob})) begin
            w_qk = NON_DEP;
            w_vk = cdb_data;
        end
    end
`else
    assign w_qj = rf_qj;
    assign w_vj = rf_vj;
    assign w_qk = rf_qk;
    assign w_vk = rf_vk;
    logic w_unused_cdb;
    assign w_unused_cdb = ^{cdb_valid, cdb_rob, cdb_data};
`endif

    always_comb begin
        w_ops.rob = rob_idx;
        w_ops.op  = w_head.opcode;
        w_ops.qj  = w_qj;
        w_ops.vj  = w_vj;
        w_ops.qk  = w_qk;
        w_ops.vk  = w_vk;
        w_ops.imm = w_head.imm;
        w_ops.pc  = w_head.pc;
        if (w_head.opcode inside {OP_IMM, OP_LOAD, OP_JALR}) begin
            w_ops.qk = NON_DEP;
            w_ops.vk = '0;
        end
        if (w_head.opcode == OP_OP) w_ops.imm = '0;
    end

    always_comb begin
        w_rob.op   = w_head.opcode;
        w_rob.rd   = w_head.rd;
        w_rob.pc   = w_head.pc;
        w_rob.npc  = w_head.pc + 32'd4;
        w_rob.pred = 1'b0;
        w_rob.rdy  = 1'b0;
        w_rob.data = '0;
        case (w_head.opcode)
            OP_LUI: begin
                w_rob.rdy  = 1'b1;
                w_rob.data = {w_head.imm[19:0], 12'b0};
            end
            OP_AUIPC: begin
                w_rob.rdy  = 1'b1;
                w_rob.data = w_head.pc + {w_head.imm[19:0], 12'b0};
            end
            OP_JAL: begin
                w_rob.rdy  = 1'b1;
                w_rob.data = w_head.pc + 32'd4;
                w_rob.npc  = w_head.pc + w_head.imm;
            end
            OP_BRANCH: begin
                w_rob.rd   = '0;
                w_rob.npc  = w_head.pc + w_head.imm;
                w_rob.pred = w_head.pred;
            end
            default: ;
        endcase
    end

    assign w_rf_write = (w_cls != ClsNone) && !(w_head.opcode inside {OP_BRANCH, OP_STORE});

    // w_pop is already low under flush or !rdy_in, so every *_en drops to 0 then.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ready  <= 1'b0;
            r_rs_en  <= 1'b0;
            r_lsb_en <= 1'b0;
            r_rob_en <= 1'b0;
            r_rf_en  <= 1'b0;
            r_ops    <= '0;
            r_rob    <= '0;
            r_rf_rob <= '0;
            r_rf_rd  <= '0;
        end else begin
            r_ready  <= 1'b1;
            r_rs_en  <= w_pop && (w_cls == ClsRs);
            r_lsb_en <= w_pop && (w_cls == ClsLsb);
            r_rob_en <= w_pop && (w_cls != ClsNone);
            r_rf_en  <= w_pop && w_rf_write;
            if (w_pop) begin
                r_ops    <= w_ops;
                r_rob    <= w_rob;
                r_rf_rob <= rob_idx;
                r_rf_rd  <= w_head.rd;
            end
        end
    end

    // RS and LSB share one field register; only the enables differ.
    assign rs_en    = r_rs_en;
    assign rs_rob   = r_ops.rob;
    assign rs_op    = r_ops.op;
    assign rs_vj    = r_ops.vj;
    assign rs_vk    = r_ops.vk;
    assign rs_qj    = r_ops.qj;
    assign rs_qk    = r_ops.qk;
    assign rs_imm   = r_ops.imm;
    assign rs_pc    = r_ops.pc;
    assign lsb_en   = r_lsb_en;
    assign lsb_rob  = r_ops.rob;
    assign lsb_op   = r_ops.op;
    assign lsb_vj   = r_ops.vj;
    assign lsb_vk   = r_ops.vk;
    assign lsb_qj   = r_ops.qj;
    assign lsb_qk   = r_ops.qk;
    assign lsb_imm  = r_ops.imm;
    assign lsb_pc   = r_ops.pc;
    assign rob_en   = r_rob_en;
    assign rob_op   = r_rob.op;
    assign rob_rd   = r_rob.rd;
    assign rob_pc   = r_rob.pc;
    assign rob_npc  = r_rob.npc;
    assign rob_pred = r_rob.pred;
    assign rob_rdy  = r_rob.rdy;
    assign rob_data = r_rob.data;
    assign rf_en    = r_rf_en;
    assign rf_rob   = r_rf_rob;
    assign rf_rd    = r_rf_rd;
endmodule

// File: tb/tb_dispatch_queue.sv
`timescale 1ns/1ps
module tb_dispatch_queue;
    import dispatch_pkg::*;

    localparam logic [3:0] ND = 4'b1000;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [3:0]  rf_qj = ND, rf_qk = ND;
    logic [31:0] rf_vj = 32'h11, rf_vk = 32'h22;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_rob = 3'd0;
    logic [31:0] cdb_data = 32'h0;
    logic        rob_full = 1'b0;
    logic [2:0]  rob_idx = 3'd5;
    logic        rs_full = 1'b0, lsb_full = 1'b0;
    logic        rs_en, lsb_en, rob_en, rf_en, rob_pred, rob_rdy;
    logic [2:0]  rs_rob, lsb_rob, rf_rob;
    logic [6:0]  rs_op, lsb_op, rob_op;
    logic [31:0] rs_vj, rs_vk, rs_imm, rs_pc, lsb_vj, lsb_vk, lsb_imm, lsb_pc;
    logic [3:0]  rs_qj, rs_qk, lsb_qj, lsb_qk;
    logic [4:0]  rob_rd, rf_rd;
    logic [31:0] rob_pc, rob_npc, rob_data;

    int n_checks = 0;
    int n_pass = 0;

    dispatch_queue_if u_if ();

    dispatch_queue #(.RoB_WIDTH(3), .QUEUE_WIDTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_if(u_if.slave),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_qj(rf_qj), .rf_qk(rf_qk),
        .rf_vj(rf_vj), .rf_vk(rf_vk),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .rob_full(rob_full), .rob_idx(rob_idx), .rs_full(rs_full), .lsb_full(lsb_full),
        .rs_en(rs_en), .rs_rob(rs_rob), .rs_op(rs_op), .rs_vj(rs_vj), .rs_vk(rs_vk),
        .rs_qj(rs_qj), .rs_qk(rs_qk), .rs_imm(rs_imm), .rs_pc(rs_pc),
        .lsb_en(lsb_en), .lsb_rob(lsb_rob), .lsb_op(lsb_op), .lsb_vj(lsb_vj),
        .lsb_vk(lsb_vk), .lsb_qj(lsb_qj), .lsb_qk(lsb_qk), .lsb_imm(lsb_imm),
        .lsb_pc(lsb_pc),
        .rob_en(rob_en), .rob_op(rob_op), .rob_rd(rob_rd), .rob_pc(rob_pc),
        .rob_npc(rob_npc), .rob_pred(rob_pred), .rob_rdy(rob_rdy), .rob_data(rob_data),
        .rf_en(rf_en), .rf_rob(rf_rob), .rf_rd(rf_rd)
    );

    logic tb_unused_sink;
    assign tb_unused_sink = ^{lsb_rob, lsb_op, lsb_vj, lsb_vk, lsb_qj, lsb_qk, rob_op};

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_inst(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic pred);
        u_if.in_valid  = 1'b1;
        u_if.in_pc     = pc;
        u_if.in_opcode = op;
        u_if.in_rs1    = rs1;
        u_if.in_rs2    = rs2;
        u_if.in_rd     = rd;
        u_if.in_imm    = imm;
        u_if.in_pred   = pred;
    endtask

    task automatic clear_inst();
        u_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++; if (u_if.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0h want 0", u_if.in_ready); else n_pass++;
        n_checks++; if ({rs_en, lsb_en, rob_en, rf_en} !== 4'b0) $display("FAIL rst_en: got %b want 0000", {rs_en, lsb_en, rob_en, rf_en}); else n_pass++;
        n_checks++; if ({rob_rdy, rob_data, rs_pc} !== 65'b0) $display("FAIL rst_data: got %0h want 0", {rob_rdy, rob_data, rs_pc}); else n_pass++;
        rst_in = 1'b0;
        step();
        n_checks++; if (u_if.in_ready !== 1'b1) $display("FAIL rel_in_ready: got %0h want 1", u_if.in_ready); else n_pass++;
    endtask

    task automatic test_lui();
        set_inst(32'h100, OP_LUI, 5'd7, 5'd8, 5'd1, 32'h12345, 1'b0);
        step();
        clear_inst();
        n_checks++; if ({rf_rs1, rf_rs2} !== 10'b0) $display("FAIL lui_rf_rs: got %0h want 0", {rf_rs1, rf_rs2}); else n_pass++;
        step();
        n_checks++; if ({rob_en, rob_rdy} !== 2'b11) $display("FAIL lui_rob_en_rdy: got %b want 11", {rob_en, rob_rdy}); else n_pass++;
        n_checks++; if (rob_data !== 32'h12345000) $display("FAIL lui_rob_data: got %0h want 12345000", rob_data); else n_pass++;
        n_checks++; if (rob_npc !== 32'h104) $display("FAIL lui_rob_npc: got %0h want 104", rob_npc); else n_pass++;
        n_checks++; if ({rs_en, lsb_en} !== 2'b00) $display("FAIL lui_no_rs_lsb: got %b want 00", {rs_en, lsb_en}); else n_pass++;
        n_checks++; if ({rf_en, rf_rob, rf_rd} !== {1'b1, 3'd5, 5'd1}) $display("FAIL lui_rf: got %0h want %0h", {rf_en, rf_rob, rf_rd}, {1'b1, 3'd5, 5'd1}); else n_pass++;
        step();
        n_checks++; if (rob_en !== 1'b0) $display("FAIL lui_pulse: got %0h want 0", rob_en); else n_pass++;
    endtask

    task automatic test_alu();
        rf_qj = 4'd2;
        set_inst(32'h200, OP_OP, 5'd1, 5'd2, 5'd3, 32'h55, 1'b0);
        step();
        clear_inst();
        n_checks++; if ({rf_rs1, rf_rs2} !== {5'd1, 5'd2}) $display("FAIL add_rf_rs: got %0h want %0h", {rf_rs1, rf_rs2}, {5'd1, 5'd2}); else n_pass++;
        step();
        n_checks++; if ({rs_en, lsb_en, rob_en, rf_en} !== 4'b1011) $display("FAIL add_en: got %b want 1011", {rs_en, lsb_en, rob_en, rf_en}); else n_pass++;
        n_checks++; if ({rs_op, rs_rob, rs_qj, rs_vj} !== {OP_OP, 3'd5, 4'd2, 32'h11}) $display("FAIL add_j: got %0h want %0h", {rs_op, rs_rob, rs_qj, rs_vj}, {OP_OP, 3'd5, 4'd2, 32'h11}); else n_pass++;
        n_checks++; if ({rs_qk, rs_vk, rs_imm} !== {ND, 32'h22, 32'h0}) $display("FAIL add_k_imm: got %0h want %0h", {rs_qk, rs_vk, rs_imm}, {ND, 32'h22, 32'h0}); else n_pass++;
        n_checks++; if ({rob_npc, rob_rdy} !== {32'h204, 1'b0}) $display("FAIL add_rob: got %0h want %0h", {rob_npc, rob_rdy}, {32'h204, 1'b0}); else n_pass++;
        rf_qj = ND;
        rf_qk = 4'd3;
        set_inst(32'h210, OP_IMM, 5'd4, 5'd6, 5'd5, 32'h7F, 1'b0);
        step();
        clear_inst();
        n_checks++; if (rf_rs2 !== 5'd0) $display("FAIL addi_rf_rs2: got %0h want 0", rf_rs2); else n_pass++;
        step();
        n_checks++; if ({rs_en, rs_qk, rs_vk, rs_imm} !== {1'b1, ND, 32'h0, 32'h7F}) $display("FAIL addi_ops: got %0h want %0h", {rs_en, rs_qk, rs_vk, rs_imm}, {1'b1, ND, 32'h0, 32'h7F}); else n_pass++;
        rf_qk = ND;
    endtask

    task automatic test_branch_jal();
        set_inst(32'h300, OP_BRANCH, 5'd1, 5'd2, 5'd9, 32'h40, 1'b1);
        step();
        clear_inst();
        step();
        n_checks++; if ({rs_en, rob_en, rf_en, rob_rdy} !== 4'b1100) $display("FAIL br_en: got %b want 1100", {rs_en, rob_en, rf_en, rob_rdy}); else n_pass++;
        n_checks++; if ({rob_npc, rob_rd, rob_pred} !== {32'h340, 5'd0, 1'b1}) $display("FAIL br_rob: got %0h want %0h", {rob_npc, rob_rd, rob_pred}, {32'h340, 5'd0, 1'b1}); else n_pass++;
        set_inst(32'h400, OP_JAL, 5'd3, 5'd4, 5'd1, 32'h20, 1'b0);
        step();
        clear_inst();
        step();
        n_checks++; if ({rs_en, rob_en, rf_en, rob_rdy} !== 4'b0111) $display("FAIL jal_en: got %b want 0111", {rs_en, rob_en, rf_en, rob_rdy}); else n_pass++;
        n_checks++; if ({rob_data, rob_npc} !== {32'h404, 32'h420}) $display("FAIL jal_rob: got %0h want %0h", {rob_data, rob_npc}, {32'h404, 32'h420}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        set_inst(32'h480, 7'h7F, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        step();
        set_inst(32'h490, OP_LUI, 5'd0, 5'd0, 5'd2, 32'h1, 1'b0);
        step();
        clear_inst();
        n_checks++; if ({rs_en, lsb_en, rob_en, rf_en} !== 4'b0) $display("FAIL unk_en: got %b want 0000", {rs_en, lsb_en, rob_en, rf_en}); else n_pass++;
        step();
        n_checks++; if ({rob_en, rob_pc, rob_data} !== {1'b1, 32'h490, 32'h1000}) $display("FAIL unk_next: got %0h want %0h", {rob_en, rob_pc, rob_data}, {1'b1, 32'h490, 32'h1000}); else n_pass++;
    endtask

    task automatic test_fill();
        rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_inst(32'h500 + 32'(4 * i), OP_IMM, 5'd1, 5'd0, 5'd2, 32'(i), 1'b0);
            step();
        end
        n_checks++; if (u_if.in_ready !== 1'b0) $display("FAIL fill_ready4: got %0h want 0", u_if.in_ready); else n_pass++;
        set_inst(32'h510, OP_IMM, 5'd1, 5'd0, 5'd2, 32'd4, 1'b0);
        step();
        n_checks++; if ({u_if.in_ready, rs_en} !== 2'b00) $display("FAIL fill_stall: got %b want 00", {u_if.in_ready, rs_en}); else n_pass++;
        rs_full = 1'b0;
        step();
        n_checks++; if ({rs_en, rs_pc, u_if.in_ready} !== {1'b1, 32'h500, 1'b1}) $display("FAIL fill_issue0: got %0h want %0h", {rs_en, rs_pc, u_if.in_ready}, {1'b1, 32'h500, 1'b1}); else n_pass++;
        for (int k = 1; k < 5; k++) begin
            step();
            clear_inst();
            n_checks++; if ({rs_en, rs_pc} !== {1'b1, 32'h500 + 32'(4 * k)}) $display("FAIL fill_issue%0d: got %0h want %0h", k, {rs_en, rs_pc}, {1'b1, 32'h500 + 32'(4 * k)}); else n_pass++;
        end
        step();
        n_checks++; if (rs_en !== 1'b0) $display("FAIL fill_drained: got %0h want 0", rs_en); else n_pass++;
    endtask

    task automatic test_lsb_stall();
        lsb_full = 1'b1;
        set_inst(32'h600, OP_STORE, 5'd1, 5'd2, 5'd0, 32'h8, 1'b0);
        step();
        set_inst(32'h604, OP_OP, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        step();
        clear_inst();
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if ({lsb_en, rs_en} !== 2'b00) $display("FAIL sw_stall%0d: got %b want 00", i, {lsb_en, rs_en}); else n_pass++;
        end
        lsb_full = 1'b0;
        step();
        n_checks++; if ({lsb_en, rs_en, rf_en, lsb_pc, lsb_imm} !== {3'b100, 32'h600, 32'h8}) $display("FAIL sw_issue: got %0h want %0h", {lsb_en, rs_en, rf_en, lsb_pc, lsb_imm}, {3'b100, 32'h600, 32'h8}); else n_pass++;
        step();
        n_checks++; if ({rs_en, lsb_en, rs_pc} !== {2'b10, 32'h604}) $display("FAIL sw_then_add: got %0h want %0h", {rs_en, lsb_en, rs_pc}, {2'b10, 32'h604}); else n_pass++;
    endtask

    task automatic test_bypass();
        rf_qj = 4'd3;
        cdb_valid = 1'b1;
        cdb_rob = 3'd3;
        cdb_data = 32'hAA;
        set_inst(32'h700, OP_OP, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        step();
        clear_inst();
        step();
`ifdef CDB_BYPASS_EN
        n_checks++; if ({rs_en, rs_qj, rs_vj} !== {1'b1, ND, 32'hAA}) $display("FAIL byp_j: got %0h want %0h", {rs_en, rs_qj, rs_vj}, {1'b1, ND, 32'hAA}); else n_pass++;
`else
        n_checks++; if ({rs_en, rs_qj, rs_vj} !== {1'b1, 4'd3, 32'h11}) $display("FAIL byp_j: got %0h want %0h", {rs_en, rs_qj, rs_vj}, {1'b1, 4'd3, 32'h11}); else n_pass++;
`endif
        n_checks++; if ({rs_qk, rs_vk} !== {ND, 32'h22}) $display("FAIL byp_k: got %0h want %0h", {rs_qk, rs_vk}, {ND, 32'h22}); else n_pass++;
        rf_qj = ND;
        cdb_valid = 1'b0;
    endtask

    task automatic test_flush();
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inst(32'h800 + 32'(4 * i), OP_IMM, 5'd1, 5'd0, 5'd2, 32'h1, 1'b0);
            step();
        end
        set_inst(32'h80C, OP_IMM, 5'd1, 5'd0, 5'd2, 32'h1, 1'b0);
        flush_in = 1'b1;
        rs_full = 1'b0;
        step();
        clear_inst();
        flush_in = 1'b0;
        n_checks++; if ({rs_en, lsb_en, rob_en, rf_en} !== 4'b0) $display("FAIL fl_en: got %b want 0000", {rs_en, lsb_en, rob_en, rf_en}); else n_pass++;
        step();
        n_checks++; if ({rs_en, u_if.in_ready} !== 2'b01) $display("FAIL fl_empty: got %b want 01", {rs_en, u_if.in_ready}); else n_pass++;
        set_inst(32'h900, OP_LUI, 5'd0, 5'd0, 5'd4, 32'h2, 1'b0);
        step();
        clear_inst();
        step();
        n_checks++; if ({rob_en, rs_en, rob_pc} !== {2'b10, 32'h900}) $display("FAIL fl_after: got %0h want %0h", {rob_en, rs_en, rob_pc}, {2'b10, 32'h900}); else n_pass++;
    endtask

    task automatic test_rdy_hold();
        set_inst(32'hA00, OP_LUI, 5'd0, 5'd0, 5'd1, 32'h3, 1'b0);
        step();
        rdy_in = 1'b0;
        set_inst(32'hA10, OP_LUI, 5'd0, 5'd0, 5'd1, 32'h4, 1'b0);
        #1;
        n_checks++; if (u_if.in_ready !== 1'b0) $display("FAIL hold_ready: got %0h want 0", u_if.in_ready); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++; if (rob_en !== 1'b0) $display("FAIL hold_en%0d: got %0h want 0", i, rob_en); else n_pass++;
        end
        rdy_in = 1'b1;
        clear_inst();
        step();
        n_checks++; if ({rob_en, rob_pc} !== {1'b1, 32'hA00}) $display("FAIL hold_resume: got %0h want %0h", {rob_en, rob_pc}, {1'b1, 32'hA00}); else n_pass++;
        step();
        n_checks++; if (rob_en !== 1'b0) $display("FAIL hold_nopush: got %0h want 0", rob_en); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_inst(32'hB00, OP_OP, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        step();
        clear_inst();
        step();
        n_checks++; if (rs_en !== 1'b1) $display("FAIL rmid_pre: got %0h want 1", rs_en); else n_pass++;
        rst_in = 1'b1;
        #1;
        n_checks++; if ({rs_en, u_if.in_ready} !== 2'b00) $display("FAIL rmid_async: got %b want 00", {rs_en, u_if.in_ready}); else n_pass++;
        step();
        n_checks++; if (u_if.in_ready !== 1'b0) $display("FAIL rmid_hold: got %0h want 0", u_if.in_ready); else n_pass++;
        rst_in = 1'b0;
        step();
        n_checks++; if ({u_if.in_ready, rs_en} !== 2'b10) $display("FAIL rmid_release: got %b want 10", {u_if.in_ready, rs_en}); else n_pass++;
    endtask

    initial begin
        u_if.in_valid  = 1'b0;
        u_if.in_pc     = '0;
        u_if.in_opcode = '0;
        u_if.in_rs1    = '0;
        u_if.in_rs2    = '0;
        u_if.in_rd     = '0;
        u_if.in_imm    = '0;
        u_if.in_pred   = 1'b0;
        test_reset();
        test_lui();
        test_alu();
        test_branch_jal();
        test_back_to_back();
        test_fill();
        test_lsb_stall();
        test_bypass();
        test_flush();
        test_rdy_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
